// File: rtl/md_pad_responder.sv
// md_pad_responder
// Mega Drive 3/6-button pad responder. Samples the reader's select line,
// counts select falls to track the protocol phase, and drives the six
// active-low pad data pins from a live 12-bit button word.
module md_pad_responder #(
    parameter int SIX_BUTTON  = 1,
    parameter int TIMEOUT_CYC = 36000,
    parameter int TW          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [11:0] buttons,
    output logic [5:0]  pins,
    output logic [2:0]  phase
);

    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

    // Button bit positions within the 12-bit button word.
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_B     = 4;
    localparam int B_C     = 5;
    localparam int B_A     = 6;
    localparam int B_START = 7;
    localparam int B_MODE  = 8;
    localparam int B_X     = 9;
    localparam int B_Y     = 10;
    localparam int B_Z     = 11;

    logic          sel_m;
    logic          sel_s;
    logic          sel_d;
    logic          sel_fall;
    logic          sel_rise;
    logic          sel_edge;
    logic [2:0]    cnt;
    logic [2:0]    cnt_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic          timer_expired;
    logic [5:0]    pin_vec;

    // Two-flop synchroniser for the asynchronous select line plus a delayed
    // copy for edge detection. All three reset to the idle-high level so that
    // leaving reset with select high produces no spurious edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_m <= 1'b1;
            sel_s <= 1'b1;
            sel_d <= 1'b1;
        end else begin
            sel_m <= sel;
            sel_s <= sel_m;
            sel_d <= sel_s;
        end
    end

    assign sel_fall      = sel_d & ~sel_s;
    assign sel_rise      = ~sel_d & sel_s;
    assign sel_edge      = sel_fall | sel_rise;
    assign timer_expired = (timer == TIMER_MAX);

    // Next phase: falls advance (wrapping 4 -> 1), an edge beats the timeout.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_next = cnt;
        if (sel_fall) begin
            if (SIX_BUTTON == 0) begin
                cnt_next = 3'd1;
            end else begin
                cnt_next = (cnt == 3'd4) ? 3'd1 : cnt + 3'd1;
            end
        end else if (!sel_rise && timer_expired) begin
            cnt_next = 3'd0;
        end
    end

    // Idle timer: cleared on any select edge, otherwise counts up and
    // saturates at the expiry value so the phase stays parked at 0.
    always_comb begin
        timer_next = timer;
        if (sel_edge) begin
            timer_next = '0;
        end else if (!timer_expired) begin
            timer_next = timer + 1'b1;
        end
    end

    // Phase counter and idle timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 3'd0;
            timer <= '0;
        end else begin
            cnt   <= cnt_next;
            timer <= timer_next;
        end
    end

    // Pin vector (1 = pressed / pulled low), ordered pin9..pin1, chosen by
    // select level and phase from the live buttons.
    always_comb begin
        pin_vec = {buttons[B_C], buttons[B_B], buttons[B_RIGHT],
                   buttons[B_LEFT], buttons[B_DOWN], buttons[B_UP]};
        if (sel_s) begin
            if (cnt == 3'd3) begin
                pin_vec = {buttons[B_C], buttons[B_B], buttons[B_MODE],
                           buttons[B_X], buttons[B_Y], buttons[B_Z]};
            end
        end else begin
            case (cnt)
                3'd3:    pin_vec = {buttons[B_START], buttons[B_A], 4'b1111};
                3'd4:    pin_vec = {buttons[B_START], buttons[B_A], 4'b0000};
                default: pin_vec = {buttons[B_START], buttons[B_A], 2'b11,
                                    buttons[B_DOWN], buttons[B_UP]};
            endcase
        end
    end

    // Registered active-low pin driver; released (all high) during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pins <= 6'b111111;
        end else begin
            pins <= ~pin_vec;
        end
    end

    assign phase = cnt;

endmodule
